signed_product_bcd_converter: RTL and testbench
===============================================

// Module: signed_product_bcd_converter
// PURPOSE
//  Sequential downstream stage of the mini calculator's 4-bit signed multiplier.
//  Accepts one signed two's-complement product over a valid/ready handshake.
//  Converts its magnitude to packed BCD with a shift-and-add-3 (double-dabble) loop.
//  Presents sign + BCD digits to the seven-segment display driver over a second
//  valid/ready handshake.
// PARAMETERS
//  WIDTH   8  signed input width; the 8-bit multiplier product
//  DIGITS  3  BCD output digits; must satisfy 10**DIGITS > 2**(WIDTH-1), elaboration $error otherwise
// PORTS
//  clk        in   1           single clock; all state updates on rising edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           product is valid this cycle
//  in_ready   out  1           converter can accept; high only in IDLE
//  product    in   WIDTH       signed two's-complement operand
//  out_valid  out  1           sign/bcd hold a finished result
//  out_ready  in   1           consumer takes result this cycle
//  sign       out  1           1 = negative result
//  bcd        out  4*DIGITS    magnitude; digit 0 in [3:0] (units), packed BCD
//  busy       out  1           high in CONVERT
// BEHAVIOUR
//  Reset: state=IDLE; sign=0, bcd=0, out_valid=0, busy=0, in_ready=1 (first cycle after reset).
//  Reset in any state, including mid-CONVERT, aborts the conversion and discards the operand.
//  FSM states: IDLE, CONVERT, DONE.
//   IDLE->CONVERT on in_valid (accept edge). At that edge:
//    - capture sign = product[WIDTH-1];
//    - capture mag = |product| as a WIDTH-bit unsigned value; -2**(WIDTH-1) gives 2**(WIDTH-1), no overflow;
//    - clear the BCD accumulator and iteration counter.
//   CONVERT: one iteration per cycle, WIDTH iterations, counter 0..WIDTH-1:
//    - every digit >= 5 gets +3;
//    - then {bcd_acc, mag} shifts left by 1.
//    CONVERT->DONE on the edge where counter == WIDTH-1.
//   DONE: out_valid=1, sign and bcd stable.
//    DONE->IDLE on out_ready; out_valid drops on that edge.
//  Latency: out_valid rises exactly WIDTH cycles after the accept edge (8 for defaults).
//  Throughput: one result per WIDTH+2 cycles minimum.
//  in_valid outside IDLE is ignored; no capture, no queueing.
//  sign/bcd outputs update only on the CONVERT->DONE edge; they hold the last result until the next completion.
//  Sign and zero: zero magnitude forces sign=0.
//  Back-pressure: out_ready low in DONE holds everything indefinitely.
//  No simultaneous accept+deliver: in_ready is 0 in DONE.
// STRUCTURE
//  calc_pkg:
//   - typedef enum logic [1:0] {IDLE, CONVERT, DONE} bcd_state_t;
//   - localparam BCD_DIGIT_W = 4;
//   - shared function abs_mag(signed) reused by the display path.
//  Sub-module bcd_add3_digit: combinational 4-bit in/out, out = (in>=5) ? in+3 : in.
//   Instantiated DIGITS times in a generate loop.
//  Counter width $clog2(WIDTH).
// TESTING
//  product=8'sd56 (0x38), in_valid 1 cycle -> 8 cycles later out_valid=1, sign=0, bcd=12'h056.
//  product=-56 (0xC8) -> sign=1, bcd=12'h056.
//  product=-128 (0x80) -> sign=1, bcd=12'h128.
//  product=127 (0x7F) -> sign=0, bcd=12'h127.
//  product=0 -> sign=0, bcd=12'h000.
//  Handshake: hold out_ready=0 for 5 cycles in DONE and drive in_valid with 0x10 meanwhile ->
//   out_valid and bcd stay 12'h056, in_ready=0, 0x10 is not captured.
//   Then out_ready=1 -> out_valid=0, IDLE next cycle.
//  Reset: assert rst on the 3rd CONVERT cycle -> next cycle out_valid=0, bcd=0, sign=0, in_ready=1.
//   A new product=0x07 then gives bcd=12'h007 with no residue from the aborted conversion.

Source files
------------

// File: rtl/signed_product_bcd_converter_pkg.sv
// Shared types and helpers for the signed-product BCD conversion path.
// Also provides the magnitude helper reused by the display path.
package signed_product_bcd_converter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      DONE    = 2'd2
   } bcd_state_t;

   localparam logic [1:0] ST_IDLE    = IDLE;
   localparam logic [1:0] ST_CONVERT = CONVERT;
   localparam logic [1:0] ST_DONE    = DONE;

   localparam int BCD_DIGIT_W = 4;

   // Magnitude of a sign-extended operand; the most negative narrow value maps
   // to its positive power of two without overflow in 32 bits.
   function automatic logic [31:0] abs_mag(input logic signed [31:0] v);
      return v[31] ? 32'(-v) : 32'(v);
   endfunction

endpackage

// File: rtl/signed_product_bcd_converter_if.sv
// Handshake bundle between the multiplier, the BCD converter and the display driver.
// master = producer/consumer side, slave = converter side.
interface signed_product_bcd_converter_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   import signed_product_bcd_converter_pkg::*;

   logic                            in_valid;
   logic                            in_ready;
   logic signed [WIDTH-1:0]         product;
   logic                            out_valid;
   logic                            out_ready;
   logic                            sign;
   logic [BCD_DIGIT_W*DIGITS-1:0]   bcd;
   logic                            busy;

   modport master (
      output in_valid, product, out_ready,
      input  in_ready, out_valid, sign, bcd, busy
   );

   modport slave (
      input  in_valid, product, out_ready,
      output in_ready, out_valid, sign, bcd, busy
   );
endinterface

// File: rtl/signed_product_bcd_converter_add3.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
// Purely combinational.
module bcd_add3_digit
   import signed_product_bcd_converter_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] i_digit,
   output logic [BCD_DIGIT_W-1:0] o_digit
);
   assign o_digit = (i_digit >= BCD_DIGIT_W'(5)) ? i_digit + BCD_DIGIT_W'(3) : i_digit;
endmodule

// File: rtl/signed_product_bcd_converter.sv
// Signed product to sign + packed BCD, one double-dabble iteration per cycle.
// out_valid rises WIDTH cycles after accept; result held in DONE until out_ready.
module signed_product_bcd_converter
   import signed_product_bcd_converter_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
)(
   input  logic                         clk,
   input  logic                         rst,
   signed_product_bcd_converter_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int BW = BCD_DIGIT_W * DIGITS;

   if ((10 ** DIGITS) <= (2 ** (WIDTH - 1))) begin : g_digits_too_few
      $error("DIGITS too small to hold the largest magnitude of a WIDTH-bit product");
   end

   logic [1:0]          r_state;
   logic [CW-1:0]       r_cnt;
   logic [WIDTH-1:0]    r_mag;
   logic [BW-1:0]       r_acc;
   logic                r_sign_cap;
   logic                r_sign;
   logic [BW-1:0]       r_bcd;

   logic [BW-1:0]       w_adj;
   logic [BW+WIDTH-1:0] w_shift;
   logic [BW-1:0]       w_acc_nxt;
   logic [WIDTH-1:0]    w_mag_nxt;
   logic                w_last;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_add3_digit u_add3 (
         .i_digit (r_acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .o_digit (w_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   assign w_shift   = {w_adj, r_mag} << 1;
   assign w_acc_nxt = w_shift[BW+WIDTH-1:WIDTH];
   assign w_mag_nxt = w_shift[WIDTH-1:0];
   assign w_last    = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_mag      <= '0;
         r_acc      <= '0;
         r_sign_cap <= 1'b0;
         r_sign     <= 1'b0;
         r_bcd      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  r_sign_cap <= bus.product[WIDTH-1];
                  r_mag      <= WIDTH'(abs_mag(32'(bus.product)));
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_state    <= ST_CONVERT;
               end
            end
            ST_CONVERT: begin
               r_acc <= w_acc_nxt;
               r_mag <= w_mag_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (w_last) begin
                  // Published outputs change only here; zero never shows as negative.
                  r_bcd   <= w_acc_nxt;
                  r_sign  <= r_sign_cap & (w_acc_nxt != '0);
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.busy      = (r_state == ST_CONVERT);
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.sign      = r_sign;
   assign bus.bcd       = r_bcd;

endmodule

// File: tb/tb_signed_product_bcd_converter.sv
// Directed bench for the signed product BCD converter.
module tb_signed_product_bcd_converter;

   logic clk;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   signed_product_bcd_converter_if #(.WIDTH(8), .DIGITS(3)) bus ();

   signed_product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Accept one product and step to the completion edge, checking timing on the way.
   task automatic run_to_done(input string tag, input logic [7:0] prod,
                              input logic exp_sign, input logic [11:0] exp_bcd);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.product  = prod;
      tick();
      bus.in_valid = 1'b0;
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      repeat (6) tick();
      chk({tag, "_early"}, 32'(bus.out_valid), 32'd0);
      tick();
      chk({tag, "_not_yet"}, 32'(bus.out_valid), 32'd0);
      tick();
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_sign"}, 32'(bus.sign), 32'(exp_sign));
      chk({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_bcd));
   endtask

   task automatic release_result(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_idle"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.product   = '0;
      bus.out_ready = 1'b0;
      repeat (2) tick();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_bcd",       32'(bus.bcd),       32'h000);
      chk("rst_sign",      32'(bus.sign),      32'd0);
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      rst = 1'b0;
      tick();

      run_to_done("p56", 8'h38, 1'b0, 12'h056);
      release_result("p56");
      run_to_done("n56", 8'hC8, 1'b1, 12'h056);
      release_result("n56");
      run_to_done("n128", 8'h80, 1'b1, 12'h128);
      release_result("n128");
      run_to_done("p127", 8'h7F, 1'b0, 12'h127);
      release_result("p127");
      run_to_done("zero", 8'h00, 1'b0, 12'h000);
      release_result("zero");

      // Back-pressure in DONE with a competing product on the input.
      run_to_done("hs", 8'h38, 1'b0, 12'h056);
      bus.in_valid = 1'b1;
      bus.product  = 8'h10;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hs_hold_valid", 32'(bus.out_valid), 32'd1);
         chk("hs_hold_bcd",   32'(bus.bcd),       32'h056);
         chk("hs_hold_rdy",   32'(bus.in_ready),  32'd0);
      end
      bus.in_valid = 1'b0;
      release_result("hs");
      tick();
      chk("hs_no_capture", 32'(bus.busy), 32'd0);

      // Reset in the third CONVERT cycle aborts the conversion.
      bus.in_valid = 1'b1;
      bus.product  = 8'h9D;
      tick();
      bus.in_valid = 1'b0;
      repeat (2) tick();
      chk("abort_busy", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_bcd",       32'(bus.bcd),       32'h000);
      chk("abort_sign",      32'(bus.sign),      32'd0);
      chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
      run_to_done("p7", 8'h07, 1'b0, 12'h007);
      release_result("p7");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
